// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - iterative 32-bit restoring divider with start/busy/done handshake
//
// One quotient bit per clock through a single 33-bit trial subtractor.
// Fixed 32-cycle latency from the accepting edge to the done pulse.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   start  in   1   request, sampled only while idle
//   sgn    in   1   signed-operation select (only with DIV32_SIGNED_EN)
//   a      in  32   dividend
//   b      in  32   divisor
//   busy   out  1   division in progress
//   done   out  1   one-cycle pulse when q/r/div0 update
//   q      out 32   quotient (held until the next result)
//   r      out 32   remainder (held until the next result)
//   div0   out  1   divisor was zero (held with q/r)
//
// Configuration macro: DIV32_SIGNED_EN enables two's-complement division
// when sgn=1; without it sgn is ignored and all divisions are unsigned.

module div32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div0
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;
  logic        w_last;

  logic [31:0] r_rem;     // working remainder
  logic [31:0] r_dvd;     // dividend shifts out, quotient shifts in
  logic [31:0] r_dvs;     // divisor magnitude
  logic [4:0]  r_cnt;
  logic [31:0] r_a;       // original dividend, returned as r on divide by zero
  logic        r_b_zero;
  logic        r_done;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic        r_div0;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_q_sgn;
  logic [31:0] w_r_sgn;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

`ifdef DIV32_SIGNED_EN
  logic r_negq;
  logic r_negr;
  logic w_neg_a;
  logic w_neg_b;

  assign w_neg_a = sgn & a[31];
  assign w_neg_b = sgn & b[31];
  assign w_mag_a = w_neg_a ? (32'd0 - a) : a;
  assign w_mag_b = w_neg_b ? (32'd0 - b) : b;
  // Truncation toward zero: quotient sign from XOR of signs, remainder
  // follows the dividend.
  assign w_q_sgn = r_negq ? (32'd0 - w_quo_nxt) : w_quo_nxt;
  assign w_r_sgn = r_negr ? (32'd0 - w_rem_nxt) : w_rem_nxt;
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_mag_a      = a;
  assign w_mag_b      = b;
  assign w_q_sgn      = w_quo_nxt;
  assign w_r_sgn      = w_rem_nxt;
`endif

  // One restoring step: shift {rem, dvd} left, trial-subtract divisor.
  // rem < dvs always holds, so the shifted value fits in 33 bits and bit 32
  // of the difference is a reliable sign.
  assign w_shift   = {r_rem, r_dvd[31]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[32];
  assign w_rem_nxt = w_qbit ? w_trial[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_dvd[30:0], w_qbit};

  // Divide by zero is forced explicitly so the signed path cannot disturb it.
  assign w_q_fin = r_b_zero ? 32'hFFFF_FFFF : w_q_sgn;
  assign w_r_fin = r_b_zero ? r_a : w_r_sgn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 5'd31) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= 32'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_cnt    <= 5'd0;
      r_a      <= 32'd0;
      r_b_zero <= 1'b0;
      r_done   <= 1'b0;
      r_q      <= 32'd0;
      r_r      <= 32'd0;
      r_div0   <= 1'b0;
`ifdef DIV32_SIGNED_EN
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_rem    <= 32'd0;
          r_dvd    <= w_mag_a;
          r_dvs    <= w_mag_b;
          r_cnt    <= 5'd0;
          r_a      <= a;
          r_b_zero <= (b == 32'd0);
`ifdef DIV32_SIGNED_EN
          r_negq   <= w_neg_a ^ w_neg_b;
          r_negr   <= w_neg_a;
`endif
        end
      end else begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_quo_nxt;
        r_cnt <= r_cnt + 5'd1;
        if (w_last) begin
          r_q    <= w_q_fin;
          r_r    <= w_r_fin;
          r_div0 <= r_b_zero;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign div0 = r_div0;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq

module tb_div32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div0;

  int n_checks;
  int n_errors;

  div32_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; the following posedge accepts the request.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    a     = ta;
    b     = tb_;
    sgn   = ts;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts posedges until done is seen; returns at the negedge of the done
  // cycle. Also watches that busy stays high and q/r do not move meanwhile.
  task automatic wait_done(output int lat, output logic hold_ok, output logic busy_ok);
    logic [31:0] q0;
    logic [31:0] r0;
    logic        seen;
    q0      = q;
    r0      = r;
    lat     = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (q !== q0 || r !== r0) hold_ok = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
  endtask

  initial begin
    int          lat;
    logic        hold_ok;
    logic        busy_ok;
    logic        seen_done;
    logic [31:0] exp_q;
    logic [31:0] exp_r;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    sgn      = 1'b0;
    a        = 32'd0;
    b        = 32'd0;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234,       1'b1};
    vecs[2]  = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0};
    vecs[3]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
    vecs[4]  = '{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,          1'b0};
    vecs[5]  = '{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0};
    vecs[6]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};
`ifdef DIV32_SIGNED_EN
    vecs[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
`else
    vecs[7]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0};
    vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          1'b0};
`endif
    vecs[10] = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q",    q,             32'd0);
    check("reset_r",    r,             32'd0);
    check("reset_div0", {31'd0, div0}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      launch(vecs[i].va, vecs[i].vb, vecs[i].vs);
      wait_done(lat, hold_ok, busy_ok);
      check($sformatf("v%0d_lat", i),  lat,                 32'd32);
      check($sformatf("v%0d_q", i),    q,                   vecs[i].eq);
      check($sformatf("v%0d_r", i),    r,                   vecs[i].er);
      check($sformatf("v%0d_div0", i), {31'd0, div0},       {31'd0, vecs[i].ed});
      check($sformatf("v%0d_busy", i), {31'd0, busy_ok},    32'd1);
      check($sformatf("v%0d_hold", i), {31'd0, hold_ok},    32'd1);
      check($sformatf("v%0d_bdone", i), {31'd0, busy},      32'd0);
      exp_q = q;
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {31'd0, done},      32'd0);
      check($sformatf("v%0d_qheld", i), q,                  exp_q);
    end

    // Back-to-back: second start issued in the done cycle.
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, hold_ok, busy_ok);
    check("b2b1_lat", lat, 32'd32);
    check("b2b1_q",   q,   32'hFFFF_FFFF);
    check("b2b1_r",   r,   32'd0);
    launch(32'd5, 32'd9, 1'b0);
    wait_done(lat, hold_ok, busy_ok);
    check("b2b2_lat",  lat,              32'd32);
    check("b2b2_q",    q,                32'd0);
    check("b2b2_r",    r,                32'd5);
    check("b2b2_hold", {31'd0, hold_ok}, 32'd1);

    // Start asserted with different operands at cycles 5..10 of a run.
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a     = 32'd999;
    b     = 32'd3;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, hold_ok, busy_ok);
    check("ign_lat", lat + 10, 32'd32);
    check("ign_q",   q,        32'd14);
    check("ign_r",   r,        32'd2);
    @(negedge clk);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN.
    @(negedge clk);
    launch(32'd1234, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q",    q,             32'd0);
    check("rst_r",    r,             32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div0", {31'd0, div0}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("rst_nodone", {31'd0, seen_done}, 32'd0);
    launch(32'd77, 32'd8, 1'b0);
    wait_done(lat, hold_ok, busy_ok);
    check("post_lat", lat, 32'd32);
    check("post_q",   q,   32'd9);
    check("post_r",   r,   32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
